// File: rtl/vec_sim_engine.sv
// -----------------------------------------------------------------------------
// vec_sim_engine
//
// Fixed-point vector similarity engine. Element pairs (a, b) arrive one per
// beat on a valid/ready stream. A single pass builds four accumulators:
// dot = sum(a*b), ma = sum(a*a), mb = sum(b*b) and dist = sum((a-b)^2).
// After N beats the engine returns one of three results:
//   mode 00 : dot product
//   mode 01 : squared Euclidean distance
//   mode 10 : cosine similarity in signed Q.FW, computed as
//             dot * 2^FW / floor(sqrt(ma*mb)) with a bit-serial restoring
//             square root (MW cycles) and restoring divider (FW+1 cycles)
//   mode 11 : reserved, returns 0 with err=1
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start, mode     job request and mode, sampled only in IDLE
//   in_valid/ready  element stream handshake, in_a/in_b signed DW-bit
//   out_valid/ready result handshake, result signed RW-bit, err qualifier
//   busy            high whenever the engine is not IDLE
//   state_dbg       current FSM state (IDLE=0 ACC=1 SQRT=2 DIV=3 OUT=4)
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. in_ready depends only on the state;
// out_valid depends only on the state, never on out_ready. While out_valid is
// high, result and err do not change until the transfer happens.
// -----------------------------------------------------------------------------
module vec_sim_engine #(
   parameter int DW = 16,
   parameter int N  = 8,
   parameter int FW = 15,
   localparam int MW = 2*DW + $clog2(N+1),
   localparam int RW = 2*DW + 2 + $clog2(N+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_a,
   input  logic signed [DW-1:0] in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [RW-1:0] result,
   output logic                 err,
   output logic                 busy,
   output logic [2:0]           state_dbg
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ACC  = 3'd1;
   localparam logic [2:0] S_SQRT = 3'd2;
   localparam logic [2:0] S_DIV  = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;

   localparam int CW = $clog2(N+1);
   localparam int IW = $clog2(MW+FW+2);
   // Shared remainder register: the sqrt trial needs MW+3 bits, the divider
   // remainder stays below 2*R and fits comfortably.
   localparam int XW = MW + 3;

   // ---------------------------------------------------------------- state
   logic [2:0]           state_q,  state_d;
   logic [1:0]           mode_q,   mode_d;
   logic [CW-1:0]        cnt_q,    cnt_d;
   logic [IW-1:0]        iter_q,   iter_d;
   logic signed [RW-1:0] dot_q,    dot_d;
   logic [MW-1:0]        ma_q,     ma_d;
   logic [MW-1:0]        mb_q,     mb_d;
   logic [RW-1:0]        dist_q,   dist_d;
   logic [2*MW-1:0]      p_q,      p_d;
   logic [XW-1:0]        rem_q,    rem_d;
   logic [MW-1:0]        root_q,   root_d;
   logic [FW:0]          quot_q,   quot_d;
   logic signed [RW-1:0] result_q, result_d;
   logic                 err_q,    err_d;

   // ------------------------------------------------------ datapath terms
   logic signed [2*DW-1:0] prod_ab, sq_a, sq_b;
   logic signed [DW:0]     diff_ab;
   logic signed [2*DW+1:0] sq_diff;
   logic signed [RW-1:0]   dot_acc;
   logic [MW-1:0]          ma_acc, mb_acc;
   logic [RW-1:0]          dist_acc;

   logic [1:0]             sq_pair;
   logic [XW-1:0]          sq_shift, sq_trial, sq_rem;
   logic                   sq_ge;
   logic [MW-1:0]          root_step;

   logic [XW-1:0]          root_ext, div_rem;
   logic                   div_ge;
   logic [FW:0]            quot_step, q_lim, q_clamp;
   logic [RW-1:0]          q_ext, abs_dot;

   always_comb begin
      // Element products; widths are chosen so none of them can wrap,
      // including (-2^(DW-1))^2 and (2^DW - 1)^2 for the difference term.
      prod_ab  = (2*DW)'(in_a) * (2*DW)'(in_b);
      sq_a     = (2*DW)'(in_a) * (2*DW)'(in_a);
      sq_b     = (2*DW)'(in_b) * (2*DW)'(in_b);
      diff_ab  = (DW+1)'(in_a) - (DW+1)'(in_b);
      sq_diff  = (2*DW+2)'(diff_ab) * (2*DW+2)'(diff_ab);

      dot_acc  = dot_q + RW'(prod_ab);
      ma_acc   = ma_q + MW'(sq_a);
      mb_acc   = mb_q + MW'(sq_b);
      dist_acc = dist_q + RW'(sq_diff);

      // One restoring square-root step: bring down the next two bits of P
      // and try to subtract (4*root + 1).
      sq_pair   = p_q[2*MW-1 -: 2];
      sq_shift  = {rem_q[MW:0], sq_pair};
      sq_trial  = {1'b0, root_q, 2'b01};
      sq_ge     = (sq_shift >= sq_trial);
      sq_rem    = sq_ge ? (sq_shift - sq_trial) : sq_shift;
      root_step = (root_q << 1) | MW'(sq_ge);

      // One restoring division step on a remainder kept below 2*R.
      root_ext  = {3'b000, root_q};
      div_ge    = (rem_q >= root_ext);
      div_rem   = (div_ge ? (rem_q - root_ext) : rem_q) << 1;
      quot_step = (quot_q << 1) | (FW+1)'(div_ge);

      // Cosine magnitude never exceeds 1.0; the clamp keeps that true even
      // if the floored root makes the quotient overshoot.
      q_lim     = (FW+1)'(1) << FW;
      q_clamp   = (quot_step > q_lim) ? q_lim : quot_step;
      q_ext     = '0;
      q_ext[FW:0] = q_clamp;

      abs_dot   = dot_q[RW-1] ? RW'(-dot_q) : RW'(dot_q);
   end

   // ------------------------------------------------------ next-state logic
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      iter_d   = iter_q;
      dot_d    = dot_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      dist_d   = dist_q;
      p_d      = p_q;
      rem_d    = rem_q;
      root_d   = root_q;
      quot_d   = quot_q;
      result_d = result_q;
      err_d    = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               cnt_d   = '0;
               dot_d   = '0;
               ma_d    = '0;
               mb_d    = '0;
               dist_d  = '0;
               state_d = S_ACC;
            end
         end

         S_ACC: begin
            if (in_valid) begin
               dot_d  = dot_acc;
               ma_d   = ma_acc;
               mb_d   = mb_acc;
               dist_d = dist_acc;
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == CW'(N-1)) begin
                  // Last beat: result is loaded from the post-beat sums.
                  cnt_d   = '0;
                  iter_d  = '0;
                  rem_d   = '0;
                  root_d  = '0;
                  quot_d  = '0;
                  p_d     = (2*MW)'(ma_acc) * (2*MW)'(mb_acc);
                  state_d = S_OUT;
                  case (mode_q)
                     2'b00: begin
                        result_d = dot_acc;
                        err_d    = 1'b0;
                     end
                     2'b01: begin
                        result_d = dist_acc;
                        err_d    = 1'b0;
                     end
                     2'b10: begin
                        if ((ma_acc != '0) && (mb_acc != '0)) begin
                           state_d = S_SQRT;
                        end else begin
                           result_d = '0;
                           err_d    = 1'b1;
                        end
                     end
                     default: begin
                        result_d = '0;
                        err_d    = 1'b1;
                     end
                  endcase
               end
            end
         end

         S_SQRT: begin
            p_d    = p_q << 2;
            rem_d  = sq_rem;
            root_d = root_step;
            iter_d = iter_q + IW'(1);
            if (iter_q == IW'(MW-1)) begin
               // root_d now holds R; the divider starts from |dot| < 2R.
               iter_d  = '0;
               rem_d   = {1'b0, abs_dot};
               quot_d  = '0;
               state_d = S_DIV;
            end
         end

         S_DIV: begin
            rem_d  = div_rem;
            quot_d = quot_step;
            iter_d = iter_q + IW'(1);
            if (iter_q == IW'(FW)) begin
               iter_d   = '0;
               result_d = dot_q[RW-1] ? -q_ext : q_ext;
               err_d    = 1'b0;
               state_d  = S_OUT;
            end
         end

         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mode_q   <= '0;
         cnt_q    <= '0;
         iter_q   <= '0;
         dot_q    <= '0;
         ma_q     <= '0;
         mb_q     <= '0;
         dist_q   <= '0;
         p_q      <= '0;
         rem_q    <= '0;
         root_q   <= '0;
         quot_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         iter_q   <= iter_d;
         dot_q    <= dot_d;
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         dist_q   <= dist_d;
         p_q      <= p_d;
         rem_q    <= rem_d;
         root_q   <= root_d;
         quot_q   <= quot_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   // --------------------------------------------------------------- outputs
   assign in_ready  = (state_q == S_ACC);
   assign out_valid = (state_q == S_OUT);
   assign busy      = (state_q != S_IDLE);
   assign result    = result_q;
   assign err       = err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_vec_sim_engine.sv
// -----------------------------------------------------------------------------
// tb_vec_sim_engine
//
// Directed bench for vec_sim_engine with DW=16, N=4, FW=15 (MW=35, RW=37).
// Cycle numbering: the edge that samples start is edge 0, the cycle after it
// is cycle 1. Inputs change and outputs are sampled 1 time unit after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_vec_sim_engine;

   localparam int DW = 16;
   localparam int N  = 4;
   localparam int FW = 15;
   localparam int RW = 2*DW + 2 + $clog2(N+1);

   // ------------------------------------------------------- clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                 start, in_valid, in_ready, out_valid, out_ready;
   logic                 err, busy;
   logic [1:0]           mode;
   logic signed [DW-1:0] in_a, in_b;
   logic signed [RW-1:0] result;
   logic [2:0]           state_dbg;

   vec_sim_engine #(.DW(DW), .N(N), .FW(FW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // ------------------------------------------------------------ scoreboard
   int     n_vec = 0;
   int     n_err = 0;
   longint exp_q[$];

   task automatic chk(input string tag, input longint obs, input longint expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic chk_result(input string tag, input longint obs);
      longint expv;
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sd0;
      chk(tag, obs, expv);
   endtask

   // ----------------------------------------------------------------- driver
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one job starting in an IDLE cycle. gaps toggles in_valid 1-0-1-0,
   // hold keeps out_ready low that many OUT cycles (with a stray start pulse),
   // pre_ready raises out_ready before OUT is reached.
   task automatic run_job(input logic [1:0] m,
                          input logic signed [DW-1:0] va [4],
                          input logic signed [DW-1:0] vb [4],
                          input bit gaps, input int hold, input bit pre_ready,
                          output longint res, output logic e,
                          output int ovc, output int stable);
      int  i;
      int  cyc;
      bit  hs;
      logic signed [RW-1:0] r0;
      start = 1'b1;
      mode  = m;
      tick();
      start = 1'b0;
      cyc   = 1;
      i     = 0;
      while (i < N && cyc < 100) begin
         in_valid = gaps ? ((cyc % 2) == 1) : 1'b1;
         in_a     = va[i];
         in_b     = vb[i];
         if (gaps && cyc == 2) start = 1'b1;
         hs = in_valid && in_ready;
         tick();
         start = 1'b0;
         if (hs) i++;
         cyc++;
      end
      in_valid = 1'b0;
      if (pre_ready) out_ready = 1'b1;
      while (!out_valid && cyc < 200) begin
         tick();
         cyc++;
      end
      ovc    = cyc;
      res    = result;
      e      = err;
      r0     = result;
      stable = 1;
      for (int k = 0; k < hold; k++) begin
         out_ready = 1'b0;
         if (k == 1) start = 1'b1;
         tick();
         start = 1'b0;
         if (result !== r0 || out_valid !== 1'b1) stable = 0;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // -------------------------------------------------------------- stimulus
   logic signed [DW-1:0] va [4];
   logic signed [DW-1:0] vb [4];
   longint res;
   logic   e;
   int     ovc;
   int     stable;

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'b00; in_valid = 1'b0;
      in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready",  in_ready,  0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy",      busy,      0);
      chk("rst_err",       err,       0);
      chk("rst_result",    result,    0);
      chk("rst_state",     state_dbg, 0);
      rst = 1'b0;
      tick();

      // Dot product
      va = '{1, 2, 3, 4}; vb = '{5, 6, 7, 8}; exp_q.push_back(70);
      run_job(2'b00, va, vb, 0, 0, 0, res, e, ovc, stable);
      chk_result("dot_res", res);
      chk("dot_err", e, 0);
      chk("dot_cycle", ovc, 5);
      chk("dot_done_out_valid", out_valid, 0);
      chk("dot_done_busy", busy, 0);

      // Squared distance, out_ready already high when OUT is entered
      va = '{1, 2, 3, 4}; vb = '{4, 3, 2, 1}; exp_q.push_back(20);
      run_job(2'b01, va, vb, 0, 0, 1, res, e, ovc, stable);
      chk_result("l2_res", res);
      chk("l2_err", e, 0);
      chk("l2_cycle", ovc, 5);
      chk("l2_done_out_valid", out_valid, 0);
      chk("l2_done_busy", busy, 0);

      // Squared distance at full-scale extremes
      va = '{-32768, -32768, -32768, -32768};
      vb = '{32767, 32767, 32767, 32767};
      exp_q.push_back(64'sd17179344900);
      run_job(2'b01, va, vb, 0, 0, 0, res, e, ovc, stable);
      chk_result("l2_ext_res", res);
      chk("l2_ext_err", e, 0);

      // Cosine: identical vectors
      va = '{3, 4, 0, 0}; vb = '{3, 4, 0, 0}; exp_q.push_back(32768);
      run_job(2'b10, va, vb, 0, 0, 0, res, e, ovc, stable);
      chk_result("cos_same_res", res);
      chk("cos_same_err", e, 0);
      chk("cos_same_cycle", ovc, 56);

      // Cosine: opposite vectors
      va = '{3, 4, 0, 0}; vb = '{-3, -4, 0, 0}; exp_q.push_back(-32768);
      run_job(2'b10, va, vb, 0, 0, 0, res, e, ovc, stable);
      chk_result("cos_opp_res", res);
      chk("cos_opp_cycle", ovc, 56);

      // Cosine: orthogonal vectors
      va = '{1, 0, 0, 0}; vb = '{0, 1, 0, 0}; exp_q.push_back(0);
      run_job(2'b10, va, vb, 0, 0, 0, res, e, ovc, stable);
      chk_result("cos_orth_res", res);
      chk("cos_orth_err", e, 0);
      chk("cos_orth_cycle", ovc, 56);

      // Cosine: 24*32768/25 = 31457.28 truncates toward zero on both signs
      va = '{3, 4, 0, 0}; vb = '{4, 3, 0, 0}; exp_q.push_back(31457);
      run_job(2'b10, va, vb, 0, 0, 0, res, e, ovc, stable);
      chk_result("cos_frac_res", res);
      va = '{3, 4, 0, 0}; vb = '{-4, -3, 0, 0}; exp_q.push_back(-31457);
      run_job(2'b10, va, vb, 0, 0, 0, res, e, ovc, stable);
      chk_result("cos_frac_neg_res", res);

      // Cosine with a zero-magnitude operand
      va = '{0, 0, 0, 0}; vb = '{1, 2, 3, 4}; exp_q.push_back(0);
      run_job(2'b10, va, vb, 0, 0, 0, res, e, ovc, stable);
      chk_result("cos_zero_res", res);
      chk("cos_zero_err", e, 1);
      chk("cos_zero_cycle", ovc, 5);

      // Reserved mode still consumes exactly N beats
      va = '{1, 2, 3, 4}; vb = '{5, 6, 7, 8}; exp_q.push_back(0);
      run_job(2'b11, va, vb, 0, 0, 0, res, e, ovc, stable);
      chk_result("rsv_res", res);
      chk("rsv_err", e, 1);
      chk("rsv_cycle", ovc, 5);

      // in_valid gaps, start pulsed while busy, out_ready held low 3 cycles
      va = '{1, 2, 3, 4}; vb = '{5, 6, 7, 8}; exp_q.push_back(70);
      run_job(2'b00, va, vb, 1, 3, 0, res, e, ovc, stable);
      chk_result("gap_res", res);
      chk("gap_err", e, 0);
      chk("gap_cycle", ovc, 8);
      chk("hold_stable", stable, 1);
      chk("hold_done_busy", busy, 0);
      chk("hold_done_out_valid", out_valid, 0);

      // Reset after two accepted beats
      start = 1'b1; mode = 2'b00;
      tick();
      start = 1'b0; in_valid = 1'b1; in_a = 16'sd7; in_b = 16'sd9;
      tick();
      tick();
      rst = 1'b1; in_valid = 1'b0;
      tick();
      rst = 1'b0;
      chk("abort_busy",      busy,      0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready",  in_ready,  0);
      chk("abort_result",    result,    0);

      va = '{1, 1, 1, 1}; vb = '{2, 2, 2, 2}; exp_q.push_back(8);
      run_job(2'b00, va, vb, 0, 0, 0, res, e, ovc, stable);
      chk_result("post_rst_res", res);
      chk("post_rst_cycle", ovc, 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
